// File: rtl/ika2151_wrseq.sv
// Write sequencer for the IKA2151 CPU bus: two-way round-robin arbitration
// into a small FIFO, replayed as address/data bus cycles with programmable
// setup/strobe/hold timing and a post-write busy interval.
module ika2151_wrseq #(
  parameter int SETUP     = 15,
  parameter int STROBE    = 20,
  parameter int HOLD      = 15,
  parameter int BUSY_WAIT = 256,
  parameter int DEPTH     = 4
) (
  input  logic                       i_EMUCLK,
  input  logic                       i_RST,
  input  logic                       i_A_REQ,
  input  logic [7:0]                 i_A_ADDR,
  input  logic [7:0]                 i_A_DATA,
  output logic                       o_A_ACK,
  input  logic                       i_B_REQ,
  input  logic [7:0]                 i_B_ADDR,
  input  logic [7:0]                 i_B_DATA,
  output logic                       o_B_ACK,
  output logic                       o_CS_n,
  output logic                       o_WR_n,
  output logic                       o_A0,
  output logic [7:0]                 o_D,
  output logic [$clog2(DEPTH):0]     o_FIFO_CNT,
  output logic                       o_IDLE
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 16;
  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LD_SETUP  = CW'(SETUP - 1);
  localparam logic [CW-1:0] LD_STROBE = CW'(STROBE - 1);
  localparam logic [CW-1:0] LD_HOLD   = CW'(HOLD - 1);
  localparam logic [CW-1:0] LD_BUSY   = CW'(BUSY_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADR_SETUP, S_ADR_STROBE, S_ADR_HOLD,
    S_DAT_SETUP, S_DAT_STROBE, S_DAT_HOLD, S_BUSY
  } state_t;

  state_t          state;
  logic [CW-1:0]   dn;
  logic            cnt_zero;
  logic            rr_b;
  logic            grant_a, grant_b, push, pop;
  logic [15:0]     push_word, head;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     fifo_cnt;
  logic [7:0]      lat_data;

  assign cnt_zero   = (dn == '0);
  assign head       = mem[rd_ptr];
  assign o_FIFO_CNT = fifo_cnt;
  assign o_IDLE     = (state == S_IDLE) && (fifo_cnt == '0);

  // Round-robin grant on the pre-pop occupancy; a requester is blocked in its ACK cycle
  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    if (fifo_cnt < FULL) begin
      grant_a = i_A_REQ && !o_A_ACK && (!(i_B_REQ && !o_B_ACK) || !rr_b);
      grant_b = i_B_REQ && !o_B_ACK && (!(i_A_REQ && !o_A_ACK) ||  rr_b);
    end
    push      = grant_a || grant_b;
    push_word = grant_a ? {i_A_ADDR, i_A_DATA} : {i_B_ADDR, i_B_DATA};
  end

  // Head is popped exactly on the edge that enters ADR_SETUP
  always_comb begin
    pop = 1'b0;
    if (fifo_cnt != '0) begin
      case (state)
        S_IDLE:     pop = 1'b1;
        S_DAT_HOLD: pop = cnt_zero && (BUSY_WAIT == 0);
        S_BUSY:     pop = cnt_zero;
        default:    pop = 1'b0;
      endcase
    end
  end

  // Arbitration pointer and one-cycle acknowledge pulses
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      rr_b    <= 1'b0;
      o_A_ACK <= 1'b0;
      o_B_ACK <= 1'b0;
    end else begin
      o_A_ACK <= grant_a;
      o_B_ACK <= grant_b;
      if (grant_a)      rr_b <= 1'b1;
      else if (grant_b) rr_b <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge i_EMUCLK) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Bus FSM: outputs are set on the edge that enters each state, so they are
  // already valid in the first cycle of that state
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      state    <= S_IDLE;
      dn       <= '0;
      o_CS_n   <= 1'b1;
      o_WR_n   <= 1'b1;
      o_A0     <= 1'b0;
      o_D      <= '0;
      lat_data <= '0;
    end else if (state == S_IDLE || (cnt_zero && (state == S_BUSY ||
                 (state == S_DAT_HOLD && BUSY_WAIT == 0)))) begin
      if (pop) begin
        state    <= S_ADR_SETUP;
        dn       <= LD_SETUP;
        o_CS_n   <= 1'b0;
        o_WR_n   <= 1'b1;
        o_A0     <= 1'b0;
        o_D      <= head[15:8];
        lat_data <= head[7:0];
      end else begin
        state  <= S_IDLE;
        o_CS_n <= 1'b1;
        o_WR_n <= 1'b1;
      end
    end else if (!cnt_zero) begin
      dn <= dn - CW'(1);
    end else begin
      case (state)
        S_ADR_SETUP: begin
          state  <= S_ADR_STROBE;
          dn     <= LD_STROBE;
          o_WR_n <= 1'b0;
        end
        S_ADR_STROBE: begin
          state  <= S_ADR_HOLD;
          dn     <= LD_HOLD;
          o_CS_n <= 1'b1;
          o_WR_n <= 1'b1;
        end
        S_ADR_HOLD: begin
          state  <= S_DAT_SETUP;
          dn     <= LD_SETUP;
          o_CS_n <= 1'b0;
          o_A0   <= 1'b1;
          o_D    <= lat_data;
        end
        S_DAT_SETUP: begin
          state  <= S_DAT_STROBE;
          dn     <= LD_STROBE;
          o_WR_n <= 1'b0;
        end
        S_DAT_STROBE: begin
          state  <= S_DAT_HOLD;
          dn     <= LD_HOLD;
          o_CS_n <= 1'b1;
          o_WR_n <= 1'b1;
        end
        S_DAT_HOLD: begin
          state <= S_BUSY;
          dn    <= LD_BUSY;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ika2151_wrseq.sv
// Directed self-checking bench for ika2151_wrseq: default-timing instance u1
// and a zero-busy-wait instance u0 sharing clock and reset.
module tb_ika2151_wrseq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req = 1'b0, b_req = 1'b0;
  logic [7:0] a_addr = '0, a_data = '0, b_addr = '0, b_data = '0;
  logic       ack_a, ack_b, cs_n, wr_n, a0, idle;
  logic [7:0] d;
  logic [2:0] cnt;

  logic       z_req = 1'b0;
  logic       z_breq = 1'b0;
  logic [7:0] z_addr = '0, z_data = '0, z_zero = '0;
  logic       z_ack_a, z_ack_b, z_cs_n, z_wr_n, z_a0, z_idle;
  logic [7:0] z_d;
  logic [2:0] z_cnt;

  int n_chk = 0;
  int n_err = 0;
  int viol1 = 0;
  int viol0 = 0;
  logic [15:0] wq[$];

  always #5 clk = ~clk;

  ika2151_wrseq u1 (
    .i_EMUCLK(clk), .i_RST(rst),
    .i_A_REQ(a_req), .i_A_ADDR(a_addr), .i_A_DATA(a_data), .o_A_ACK(ack_a),
    .i_B_REQ(b_req), .i_B_ADDR(b_addr), .i_B_DATA(b_data), .o_B_ACK(ack_b),
    .o_CS_n(cs_n), .o_WR_n(wr_n), .o_A0(a0), .o_D(d),
    .o_FIFO_CNT(cnt), .o_IDLE(idle)
  );

  ika2151_wrseq #(.BUSY_WAIT(0)) u0 (
    .i_EMUCLK(clk), .i_RST(rst),
    .i_A_REQ(z_req), .i_A_ADDR(z_addr), .i_A_DATA(z_data), .o_A_ACK(z_ack_a),
    .i_B_REQ(z_breq), .i_B_ADDR(z_zero), .i_B_DATA(z_zero), .o_B_ACK(z_ack_b),
    .o_CS_n(z_cs_n), .o_WR_n(z_wr_n), .o_A0(z_a0), .o_D(z_d),
    .o_FIFO_CNT(z_cnt), .o_IDLE(z_idle)
  );

  // Bus monitor for u1: protocol rules plus capture of completed writes
  logic       p1_cs = 1'b1, p1_wr = 1'b1, p1_a0 = 1'b0;
  logic [7:0] p1_d = '0, cur_addr = '0;
  always @(negedge clk) begin
    if (rst) begin
      p1_cs = 1'b1; p1_wr = 1'b1;
    end else begin
      if (!wr_n && cs_n) viol1++;
      if (!cs_n && !p1_cs && (a0 !== p1_a0 || d !== p1_d)) viol1++;
      if (!wr_n && p1_wr) begin
        if (!a0) cur_addr = d;
        else     wq.push_back({cur_addr, d});
      end
      p1_cs = cs_n; p1_wr = wr_n; p1_a0 = a0; p1_d = d;
    end
  end

  // Bus protocol monitor for u0
  logic       p0_cs = 1'b1, p0_a0 = 1'b0;
  logic [7:0] p0_d = '0;
  always @(negedge clk) begin
    if (rst) begin
      p0_cs = 1'b1;
    end else begin
      if (!z_wr_n && z_cs_n) viol0++;
      if (!z_cs_n && !p0_cs && (z_a0 !== p0_a0 || z_d !== p0_d)) viol0++;
      p0_cs = z_cs_n; p0_a0 = z_a0; p0_d = z_d;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    a_req = 1'b0; b_req = 1'b0; z_req = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    wq.delete();
  endtask

  task automatic wait_idle(input int lim, input string name);
    int c = 0;
    while (!idle && c < lim) begin
      step();
      c++;
    end
    chk(name, 32'(idle), 32'd1);
  endtask

  task automatic chk_queue(input string name, input logic [15:0] exp[$]);
    chk({name, " count"}, 32'(wq.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < wq.size()) chk($sformatf("%s word%0d", name, i), 32'(wq[i]), 32'(exp[i]));
    end
  endtask

  typedef struct {
    logic cs, wr, a0;
    logic [7:0] d;
    int len;
  } ph_t;

  typedef struct {
    logic a_req; logic [7:0] a_addr, a_data;
    logic b_req; logic [7:0] b_addr, b_data;
    logic ack_a, ack_b;
    logic [2:0] cnt;
  } vec_t;

  ph_t  ph[7];
  vec_t cv[6];
  logic [15:0] expq[$];

  initial begin
    int bad, idx, cyc, max_cnt, ack_full, full_cyc, cs_low;
    logic prev_full;

    ph[0] = '{1'b0, 1'b1, 1'b0, 8'h18, 15};
    ph[1] = '{1'b0, 1'b0, 1'b0, 8'h18, 20};
    ph[2] = '{1'b1, 1'b1, 1'b0, 8'h18, 15};
    ph[3] = '{1'b0, 1'b1, 1'b1, 8'hFF, 15};
    ph[4] = '{1'b0, 1'b0, 1'b1, 8'hFF, 20};
    ph[5] = '{1'b1, 1'b1, 1'b1, 8'hFF, 15};
    ph[6] = '{1'b1, 1'b1, 1'b1, 8'hFF, 256};

    cv[0] = '{1'b1, 8'h1B, 8'h01, 1'b1, 8'h28, 8'h3A, 1'b1, 1'b0, 3'd1};
    cv[1] = '{1'b1, 8'h1C, 8'h02, 1'b1, 8'h28, 8'h3A, 1'b0, 1'b1, 3'd1};
    cv[2] = '{1'b1, 8'h1C, 8'h02, 1'b1, 8'h29, 8'h3B, 1'b1, 1'b0, 3'd2};
    cv[3] = '{1'b1, 8'h1D, 8'h03, 1'b1, 8'h29, 8'h3B, 1'b0, 1'b1, 3'd3};
    cv[4] = '{1'b1, 8'h1D, 8'h03, 1'b1, 8'h2A, 8'h3C, 1'b1, 1'b0, 3'd4};
    cv[5] = '{1'b1, 8'h1E, 8'h04, 1'b1, 8'h2A, 8'h3C, 1'b0, 1'b0, 3'd4};

    // Reset state
    step();
    chk("rst cs_n", 32'(cs_n), 32'd1);
    chk("rst wr_n", 32'(wr_n), 32'd1);
    chk("rst a0", 32'(a0), 32'd0);
    chk("rst d", 32'(d), 32'h00);
    chk("rst acks", 32'({ack_a, ack_b}), 32'd0);
    chk("rst cnt", 32'(cnt), 32'd0);
    chk("rst idle", 32'(idle), 32'd1);
    rst = 1'b0;
    step();

    // Single write with the default timing
    a_req = 1'b1; a_addr = 8'h18; a_data = 8'hFF;
    step();
    chk("single ack", 32'(ack_a), 32'd1);
    chk("single cnt", 32'(cnt), 32'd1);
    chk("single cs before start", 32'(cs_n), 32'd1);
    a_req = 1'b0;
    step();
    for (int p = 0; p < 7; p++) begin
      bad = 0;
      for (int i = 0; i < ph[p].len; i++) begin
        if (cs_n !== ph[p].cs || wr_n !== ph[p].wr || a0 !== ph[p].a0 ||
            d !== ph[p].d || idle !== 1'b0 || ack_a !== 1'b0) bad++;
        step();
      end
      chk($sformatf("single phase%0d bad cycles", p), 32'(bad), 32'd0);
    end
    chk("single idle after", 32'(idle), 32'd1);
    chk("single cs after", 32'(cs_n), 32'd1);

    // Contention: both requesters held for 6 cycles
    do_reset();
    for (int k = 0; k < 6; k++) begin
      a_req = cv[k].a_req; a_addr = cv[k].a_addr; a_data = cv[k].a_data;
      b_req = cv[k].b_req; b_addr = cv[k].b_addr; b_data = cv[k].b_data;
      step();
      chk($sformatf("cont%0d ack_a", k), 32'(ack_a), 32'(cv[k].ack_a));
      chk($sformatf("cont%0d ack_b", k), 32'(ack_b), 32'(cv[k].ack_b));
      chk($sformatf("cont%0d cnt", k), 32'(cnt), 32'(cv[k].cnt));
    end
    a_req = 1'b0; b_req = 1'b0;
    wait_idle(3000, "cont idle");
    expq = '{16'h1B01, 16'h283A, 16'h1C02, 16'h293B, 16'h1D03};
    chk_queue("cont bus", expq);

    // Full FIFO: A streams 6 words
    do_reset();
    idx = 0; cyc = 0; max_cnt = 0; ack_full = 0; full_cyc = 0; prev_full = 1'b0;
    a_req = 1'b1; a_addr = 8'h30; a_data = 8'hA0;
    while (idx < 6 && cyc < 3000) begin
      step();
      cyc++;
      if (ack_a && prev_full) ack_full++;
      if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
      if (cnt == 3'd4) full_cyc++;
      prev_full = (cnt == 3'd4);
      if (ack_a) begin
        idx++;
        if (idx < 6) begin
          a_addr = 8'h30 + 8'(idx);
          a_data = 8'hA0 + 8'(idx);
        end else begin
          a_req = 1'b0;
        end
      end
    end
    chk("full all acked", 32'(idx), 32'd6);
    chk("full max cnt", 32'(max_cnt), 32'd4);
    chk("full ack while full", 32'(ack_full), 32'd0);
    chk("full held off long", 32'(full_cyc >= 300), 32'd1);
    wait_idle(3000, "full idle");
    expq = '{16'h30A0, 16'h31A1, 16'h32A2, 16'h33A3, 16'h34A4, 16'h35A5};
    chk_queue("full bus", expq);

    // Reset during DAT_STROBE with two entries queued
    do_reset();
    idx = 0; cyc = 0;
    a_req = 1'b1; a_addr = 8'h40; a_data = 8'h50;
    while (idx < 3 && cyc < 50) begin
      step();
      cyc++;
      if (ack_a) begin
        idx++;
        a_addr = 8'h40 + 8'(idx);
        a_data = 8'h50 + 8'(idx);
      end
    end
    a_req = 1'b0;
    chk("rstmid pushes", 32'(idx), 32'd3);
    chk("rstmid queued", 32'(cnt), 32'd2);
    cyc = 0;
    while (!(a0 && !wr_n) && cyc < 200) begin
      step();
      cyc++;
    end
    chk("rstmid reached dat strobe", 32'(a0 && !wr_n), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid cs_n", 32'(cs_n), 32'd1);
    chk("rstmid wr_n", 32'(wr_n), 32'd1);
    chk("rstmid cnt", 32'(cnt), 32'd0);
    chk("rstmid idle", 32'(idle), 32'd1);
    step();
    rst = 1'b0;
    step();
    wq.delete();
    cs_low = 0;
    for (int i = 0; i < 400; i++) begin
      if (!cs_n) cs_low++;
      step();
    end
    chk("rstmid quiet bus", 32'(cs_low), 32'd0);
    chk("rstmid cnt after", 32'(cnt), 32'd0);
    a_req = 1'b1; a_addr = 8'h55; a_data = 8'hAA;
    step();
    a_req = 1'b0;
    wait_idle(500, "rstmid new idle");
    expq = '{16'h55AA};
    chk_queue("rstmid bus", expq);

    // Zero busy wait on u0: two back-to-back writes of 100 clocks each
    do_reset();
    z_req = 1'b1; z_addr = 8'h60; z_data = 8'h61;
    step();
    chk("zbw ack0", 32'(z_ack_a), 32'd1);
    z_addr = 8'h62; z_data = 8'h63;
    step();
    chk("zbw start", 32'({z_cs_n, z_a0, z_d}), 32'({1'b0, 1'b0, 8'h60}));
    step();
    chk("zbw ack1", 32'(z_ack_a), 32'd1);
    z_req = 1'b0;
    for (int off = 2; off <= 200; off++) begin
      step();
      if (off == 99)  chk("zbw last hold", 32'({z_cs_n, z_a0, z_d}), 32'({1'b1, 1'b1, 8'h61}));
      if (off == 100) begin
        chk("zbw second start", 32'({z_cs_n, z_wr_n, z_a0, z_d}), 32'({1'b0, 1'b1, 1'b0, 8'h62}));
        chk("zbw cnt drained", 32'(z_cnt), 32'd0);
      end
      if (off == 199) chk("zbw second hold", 32'({z_cs_n, z_a0, z_d, z_idle}), 32'({1'b1, 1'b1, 8'h63, 1'b0}));
      if (off == 200) chk("zbw idle", 32'(z_idle), 32'd1);
    end

    chk("protocol u1 violations", 32'(viol1), 32'd0);
    chk("protocol u0 violations", 32'(viol0), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ika2151_wrseq.md
# ika2151_wrseq

Host-side write sequencer for the IKA2151 core. It accepts register writes (address, data) from two requesters, arbitrates between them round-robin, and buffers them in a small FIFO. It then replays each write onto the core's CPU bus (`CS_n`/`WR_n`/`A0`/`D`) as an address cycle followed by a data cycle, using programmable strobe timing and a post-write busy interval. It sits between system logic and `IKA2151`, whose `i_RD_n` is tied high by the integrator.

## Interface
- `SETUP`, default 15: clocks `CS_n` is low with `WR_n` high before the strobe. Must be ≥ 1.
- `STROBE`, default 20: clocks `WR_n` is low. Must be ≥ 1.
- `HOLD`, default 15: clocks `CS_n`/`WR_n` are high after each strobe, with `A0`/`D` held. Must be ≥ 1.
- `BUSY_WAIT`, default 256: idle clocks after each data cycle (chip busy time). 0 means no wait.
- `DEPTH`, default 4: FIFO entries. Must be a power of 2, ≥ 2.

- `i_EMUCLK`, in, 1: the single clock. Everything is on its rising edge.
- `i_RST`, in, 1: asynchronous, active-high reset.
- `i_A_REQ`, in, 1: requester A has a write pending (level).
- `i_A_ADDR`, in, 8: requester A register address.
- `i_A_DATA`, in, 8: requester A register data.
- `o_A_ACK`, out, 1: one-cycle pulse; A's word was pushed on the previous edge.
- `i_B_REQ`, `i_B_ADDR`, `i_B_DATA`, `o_B_ACK`: same as A, for requester B.
- `o_CS_n`, out, 1: chip select to the core.
- `o_WR_n`, out, 1: write strobe to the core.
- `o_A0`, out, 1: 0 = address cycle, 1 = data cycle.
- `o_D`, out, 8: bus data to the core.
- `o_FIFO_CNT`, out, log2(DEPTH)+1: current FIFO occupancy.
- `o_IDLE`, out, 1: high when the FSM is in IDLE and the FIFO is empty.

## Operation
- **Reset (asynchronous, immediate):**
  - Outputs: `o_CS_n`=1, `o_WR_n`=1, `o_A0`=0, `o_D`=0x00, both ACKs 0, `o_FIFO_CNT`=0, `o_IDLE`=1.
  - Internal: FSM in IDLE, round-robin pointer set to A, all counters 0.
  - Reset mid-transaction aborts the transaction and discards the FIFO contents. The strobe deasserts without waiting for a clock.
- **Arbitration (combinational grant, registered effects):**
  - A requester is eligible when its REQ=1 and its ACK is 0 in the current cycle.
  - A grant is issued only when `o_FIFO_CNT` < DEPTH. The pre-pop count is used, so a pop in the same cycle does not free a slot.
  - One eligible requester: it is granted. Both eligible: the pointer's side is granted.
  - On any grant, the pointer moves to the other requester.
  - Granted word {ADDR, DATA} is pushed at the edge. The matching ACK is 1 for the following cycle only.
  - A requester keeping REQ high after its ACK gets a new push no earlier than 2 cycles after the first.
- **FIFO:** circular, pointers wrap modulo DEPTH. A push and a pop on the same edge leave the count unchanged.
- **FSM states:** IDLE → ADR_SETUP → ADR_STROBE → ADR_HOLD → DAT_SETUP → DAT_STROBE → DAT_HOLD → BUSY → (ADR_SETUP if FIFO not empty, else IDLE).
  - A single down-counter is loaded on each state entry with that state's parameter minus 1. The state is left when the counter = 0.
  - BUSY is skipped when `BUSY_WAIT`=0.
  - IDLE → ADR_SETUP when count > 0. The FIFO head is popped on that edge and latched as {addr, data}.
- **Registered outputs per state:**
  - IDLE: `CS_n`=1, `WR_n`=1; `A0`/`D` keep their last values.
  - ADR_SETUP: `CS_n`=0, `WR_n`=1, `A0`=0, `D`=addr.
  - ADR_STROBE: `CS_n`=0, `WR_n`=0, `A0`=0, `D`=addr.
  - ADR_HOLD: `CS_n`=1, `WR_n`=1, `A0`=0, `D`=addr.
  - DAT_SETUP: `CS_n`=0, `WR_n`=1, `A0`=1, `D`=data.
  - DAT_STROBE: `CS_n`=0, `WR_n`=0, `A0`=1, `D`=data.
  - DAT_HOLD and BUSY: `CS_n`=1, `WR_n`=1, `A0`=1, `D`=data.
- **Bus invariants:**
  - `A0` and `D` never change in a cycle where `CS_n`=0.
  - `WR_n`=0 never occurs while `CS_n`=1.

## Timing
- **Push latency:** REQ seen in cycle t → word in FIFO and ACK=1 in cycle t+1.
- **Bus start latency:** FIFO non-empty in IDLE at cycle t → `CS_n` falls in cycle t+1.
- **Write length:** one write is 2·(SETUP+STROBE+HOLD) + BUSY_WAIT clocks, from `CS_n` fall to the next possible `CS_n` fall. Defaults: 100 + 256 = 356 clocks.
- **Back-to-back writes:** there is no IDLE cycle between queued writes. The cycle after BUSY is ADR_SETUP.
- **`o_IDLE`:** 1 exactly in cycles where state=IDLE and count=0.
- **Full FIFO:** REQ is held off (no ACK) until the count drops below DEPTH. No word is ever lost or duplicated.

## Test plan
- **Single write:** A pushes 0x18/0xFF.
  - Required: ACK one cycle later. `CS_n` low 35 clocks with `A0`=0, `D`=0x18, and `WR_n` low for clocks 16–35 of that window. 15 clocks high. Then the same pattern with `A0`=1, `D`=0xFF. Then 256 busy clocks, then `o_IDLE`=1.
- **Contention:** A (0x1B/0x01) and B (0x28/0x3A) both held high for 6 cycles, each advancing to a new word after its ACK.
  - Required: push order A, B, A, B; bus replays the writes in that order.
- **Full FIFO:** A streams 6 words with `DEPTH`=4.
  - Required: `o_FIFO_CNT` saturates at 4. ACK withheld until the first pop. All 6 words appear on the bus in order.
- **Reset mid-write:** assert `i_RST` during DAT_STROBE with 2 entries queued.
  - Required: `CS_n`/`WR_n`=1 immediately, count=0. After release, no bus activity until a new REQ.
- **Zero busy wait:** `BUSY_WAIT`=0, two queued writes.
  - Required: the second ADR_SETUP starts the clock after the first DAT_HOLD ends. Each write takes exactly 100 clocks.
- **Bus protocol checker:** runs on all tests.
  - Required: `WR_n`=0 never occurs with `CS_n`=1, and `A0`/`D` are stable whenever `CS_n`=0.
